// File: rtl/pacman_input_pkg.sv
// pacman_input_pkg: shared definitions for the key debouncer.
//   NUM_BUTTONS        number of board keys handled by button_debounce
//   db_state_e         per-key debounce FSM state
//   UP/DOWN/LEFT/RIGHT index of each key in the button vectors
//   cnt_width()        counter width able to hold the largest timing parameter
package pacman_input_pkg;

   localparam int unsigned NUM_BUTTONS = 4;

   localparam int unsigned UP    = 0;
   localparam int unsigned DOWN  = 1;
   localparam int unsigned LEFT  = 2;
   localparam int unsigned RIGHT = 3;

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StHeld,
      StReleaseWait
   } db_state_e;

   // $clog2 of the largest parameter plus one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one key's synchronizer, debounce FSM and counters.
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   raw_i    asynchronous raw key input
//   level_o  debounced active-high level (1 in StHeld and StReleaseWait)
//   pulse_o  one-cycle pulse on an accepted press, plus auto-repeat pulses
// Build option: BUTTON_REPEAT_EN adds the auto-repeat counter in StHeld.
module debounce_bit
   import pacman_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic raw_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int unsigned    CntW        = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CntW-1:0] DbLast     = CntW'(DEBOUNCE_CYCLES - 1);
   localparam bit             SingleCycle = (DEBOUNCE_CYCLES == 1);
   localparam logic           RawIdle     = ACTIVE_LOW;

   logic            s1_q, s2_q;
   logic            sync;
   db_state_e       state_q;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_inc;
   logic            level_q;
   logic            pulse_q;

   assign sync    = ACTIVE_LOW ? ~s2_q : s2_q;
   // Saturating increment: the counter never wraps.
   assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

`ifdef BUTTON_REPEAT_EN
   logic [CntW-1:0] rep_q;
   logic [CntW-1:0] rep_inc;
   logic [CntW-1:0] rep_limit;
   logic            rep_armed_q;

   assign rep_inc   = (rep_q == {CntW{1'b1}}) ? rep_q : rep_q + CntW'(1);
   // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_RATE.
   assign rep_limit = rep_armed_q ? CntW'(REPEAT_RATE) : CntW'(REPEAT_DELAY);
`endif

   // The edge that leaves StIdle/StHeld already counts as the first stable
   // cycle, so the change is accepted when the incremented count hits
   // DEBOUNCE_CYCLES-1; total latency is 2 sync edges + DEBOUNCE_CYCLES.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s1_q        <= RawIdle;
         s2_q        <= RawIdle;
         state_q     <= StIdle;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         pulse_q     <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         rep_q       <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         pulse_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
`ifdef BUTTON_REPEAT_EN
               rep_q       <= '0;
               rep_armed_q <= 1'b0;
`endif
               if (sync) begin
                  if (SingleCycle) begin
                     state_q <= StHeld;
                     level_q <= 1'b1;
                     pulse_q <= 1'b1;
                  end else begin
                     state_q <= StPressWait;
                     cnt_q   <= '0;
                  end
               end
            end
            StPressWait: begin
               if (!sync) begin
                  state_q <= StIdle;
               end else if (cnt_inc == DbLast) begin
                  state_q <= StHeld;
                  level_q <= 1'b1;
                  pulse_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StHeld: begin
               if (!sync) begin
                  if (SingleCycle) begin
                     state_q <= StIdle;
                     level_q <= 1'b0;
                  end else begin
                     state_q <= StReleaseWait;
                     cnt_q   <= '0;
                  end
               end
`ifdef BUTTON_REPEAT_EN
               else if (rep_inc == rep_limit) begin
                  pulse_q     <= 1'b1;
                  rep_q       <= '0;
                  rep_armed_q <= 1'b1;
               end else begin
                  rep_q <= rep_inc;
               end
`endif
            end
            StReleaseWait: begin
               // Repeat counter holds here and resumes on return to StHeld.
               if (sync) begin
                  state_q <= StHeld;
               end else if (cnt_inc == DbLast) begin
                  state_q <= StIdle;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: debounces NUM_BUTTONS board keys independently.
//   HCLK         clock
//   HRESETn      asynchronous active-low reset
//   buttons_raw  asynchronous raw key inputs (active-low when ACTIVE_LOW=1)
//   buttons      debounced active-high levels
//   press_pulse  one-cycle pulse per accepted press (plus auto-repeat)
//   any_held     OR of buttons
// Build option: BUTTON_REPEAT_EN enables auto-repeat pulses while held.
module button_debounce
   import pacman_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_BUTTONS-1:0] buttons_raw,
   output logic [NUM_BUTTONS-1:0] buttons,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic                   any_held
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_bit (
         .HCLK    (HCLK),
         .HRESETn (HRESETn),
         .raw_i   (buttons_raw[i]),
         .level_o (buttons[i]),
         .pulse_o (press_pulse[i])
      );
   end

   assign any_held = |buttons;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
   import pacman_input_pkg::*;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 20;
   localparam int unsigned RR = 8;

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   logic [3:0] buttons_raw = 4'hF;
   logic [3:0] buttons;
   logic [3:0] press_pulse;
   logic       any_held;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   button_debounce #(
      .DEBOUNCE_CYCLES (DB),
      .ACTIVE_LOW      (1'b1),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .buttons_raw (buttons_raw),
      .buttons     (buttons),
      .press_pulse (press_pulse),
      .any_held    (any_held)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   // Monitor: pops the scoreboard whenever a pulse appears.
   always @(negedge HCLK) begin
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         mon_e = sb_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_pulse: got none by cycle %0d, required %b at cycle %0d",
                  cyc, mon_e.vec, mon_e.cyc);
      end
      if (press_pulse != 4'b0000) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got %b at cycle %0d, required none",
                     press_pulse, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.vec !== press_pulse || mon_e.cyc != cyc) begin
               n_fail++;
               $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                        press_pulse, cyc, mon_e.vec, mon_e.cyc);
            end
         end
      end
   end

   task automatic expect_pulse(input int at, input logic [3:0] v);
      exp_t e;
      e.cyc = at;
      e.vec = v;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic step_to(input int t);
      while (cyc < t) @(negedge HCLK);
   endtask

   int         c0, c1, c2, cr;
   logic [11:0] bounce_pat;

   initial begin
      // Reset state
      repeat (3) @(negedge HCLK);
      chk("reset_buttons", buttons, 4'b0000);
      chk("reset_pulse", press_pulse, 4'b0000);
      chk("reset_any", {3'b000, any_held}, 4'b0000);
      HRESETn = 1'b1;
      repeat (4) @(negedge HCLK);

      // Clean press and release on UP
      c0 = cyc;
      buttons_raw[UP] = 1'b0;
      expect_pulse(c0 + 6, 4'b0001);
      step_to(c0 + 5);
      chk("press_latency_pre", buttons, 4'b0000);
      step_to(c0 + 6);
      chk("press_level", buttons, 4'b0001);
      chk("press_any", {3'b000, any_held}, 4'b0001);
      step_to(c0 + 10);
      c0 = cyc;
      buttons_raw[UP] = 1'b1;
      step_to(c0 + 5);
      chk("release_latency_pre", buttons, 4'b0001);
      step_to(c0 + 6);
      chk("release_level", buttons, 4'b0000);
      chk("release_any", {3'b000, any_held}, 4'b0000);
      repeat (4) @(negedge HCLK);

      // Bounce on DOWN: low 3, high 1, low 2, then high
      bounce_pat = 12'b1111_1100_1000;
      for (int k = 0; k < 12; k++) begin
         buttons_raw[DOWN] = bounce_pat[k];
         chk("bounce_buttons", buttons, 4'b0000);
         @(negedge HCLK);
      end
      repeat (4) @(negedge HCLK);
      chk("bounce_after", buttons, 4'b0000);

      // Release glitch on LEFT
      c0 = cyc;
      buttons_raw[LEFT] = 1'b0;
      expect_pulse(c0 + 6, 4'b0100);
      step_to(c0 + 8);
      chk("glitch_held", buttons, 4'b0100);
      c1 = cyc;
      buttons_raw[LEFT] = 1'b1;
      step_to(c1 + 2);
      buttons_raw[LEFT] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge HCLK);
         chk("glitch_level", buttons, 4'b0100);
      end
      c2 = cyc;
      buttons_raw[LEFT] = 1'b1;
      step_to(c2 + 5);
      chk("glitch_release_pre", buttons, 4'b0100);
      step_to(c2 + 6);
      chk("glitch_release", buttons, 4'b0000);
      repeat (4) @(negedge HCLK);

      // Long hold on RIGHT for 60 cycles
      c0 = cyc;
      buttons_raw[RIGHT] = 1'b0;
      expect_pulse(c0 + 6, 4'b1000);
`ifdef BUTTON_REPEAT_EN
      for (int t = 6 + RD; t <= 62; t += RR) expect_pulse(c0 + t, 4'b1000);
`endif
      step_to(c0 + 30);
      chk("hold_level", buttons, 4'b1000);
      step_to(c0 + 60);
      buttons_raw[RIGHT] = 1'b1;
      step_to(c0 + 70);
      chk("hold_released", buttons, 4'b0000);
      repeat (4) @(negedge HCLK);

      // Reset while UP is held and DOWN is mid-debounce
      c0 = cyc;
      buttons_raw[UP] = 1'b0;
      expect_pulse(c0 + 6, 4'b0001);
      step_to(c0 + 8);
      buttons_raw[DOWN] = 1'b0;
      step_to(c0 + 12);
      chk("prereset_held", buttons, 4'b0001);
      HRESETn = 1'b0;
      #1;
      chk("midreset_buttons", buttons, 4'b0000);
      chk("midreset_pulse", press_pulse, 4'b0000);
      chk("midreset_any", {3'b000, any_held}, 4'b0000);
      repeat (2) @(negedge HCLK);
      cr = cyc;
      HRESETn = 1'b1;
      expect_pulse(cr + 6, 4'b0011);
      step_to(cr + 5);
      chk("postreset_pre", buttons, 4'b0000);
      step_to(cr + 6);
      chk("postreset_level", buttons, 4'b0011);
      step_to(cr + 8);
      buttons_raw = 4'hF;
      step_to(cr + 16);
      chk("postreset_release", buttons, 4'b0000);

      // Simultaneous UP + RIGHT
      c0 = cyc;
      buttons_raw = 4'b0110;
      expect_pulse(c0 + 6, 4'b1001);
      step_to(c0 + 6);
      chk("simul_level", buttons, 4'b1001);
      step_to(c0 + 8);
      buttons_raw = 4'hF;
      step_to(c0 + 16);
      chk("simul_release", buttons, 4'b0000);

      repeat (4) @(negedge HCLK);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending pulses, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 500000: stable cycles required to accept a level change. Minimum 1.
- ACTIVE_LOW, 1: raw inputs are active-low board keys.
- REPEAT_DELAY, 25000000: HELD cycles before the first auto-repeat pulse.
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat pulses. Minimum 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- HCLK, in, 1: clock.
- HRESETn, in, 1: reset, asynchronous, active-low.
- buttons_raw, in, 4: asynchronous raw key inputs.
- buttons, out, 4: debounced active-high level; feeds the button-register stage.
- press_pulse, out, 4: one-cycle pulse per accepted press, plus auto-repeat pulses.
- any_held, out, 1: OR of buttons.

Function
REQ-003 Each buttons_raw bit SHALL pass through a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1, giving sync[i].
REQ-004 Each bit SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-005 IDLE: sync=1 SHALL move to PRESS_WAIT with the debounce counter cleared to 0.
REQ-006 PRESS_WAIT: sync=0 SHALL return to IDLE; sync=1 SHALL increment the counter.
REQ-007 PRESS_WAIT: sync=1 with counter=DEBOUNCE_CYCLES-1 SHALL move to HELD.
REQ-008 On entering HELD from PRESS_WAIT, buttons[i] SHALL be 1 and press_pulse[i] SHALL be 1 for exactly one cycle.
REQ-009 HELD: sync=0 SHALL move to RELEASE_WAIT with the counter cleared.
REQ-010 RELEASE_WAIT: sync=1 SHALL return to HELD with no press_pulse.
REQ-011 RELEASE_WAIT: sync=0 with counter=DEBOUNCE_CYCLES-1 SHALL move to IDLE and clear buttons[i].
REQ-012 buttons[i] SHALL be 1 in HELD and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-013 Latency SHALL be exactly 2+DEBOUNCE_CYCLES rising edges from the first edge sampling a stable raw change to the buttons change.
REQ-014 Counters SHALL be $clog2(max parameter)+1 bits wide and SHALL saturate, never wrap.
REQ-015 Bits SHALL be fully independent: simultaneous presses on several bits give simultaneous pulses.
REQ-016 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no change on buttons and no pulse.

Reset
REQ-017 HRESETn low SHALL asynchronously set every bit to:
- synchronizer flops to the inactive raw level;
- FSM state to IDLE;
- all counters to 0;
- buttons=0, press_pulse=0, any_held=0.
REQ-018 A key held through reset release SHALL be treated as a new press: full debounce, then one pulse.

Configuration
REQ-019 With BUTTON_REPEAT_EN defined, HELD SHALL count cycles.
- A pulse SHALL fire after REPEAT_DELAY cycles, then every REPEAT_RATE cycles, while the bit remains in HELD.
- The repeat counter SHALL hold its value in RELEASE_WAIT and resume on return to HELD.
- The repeat counter SHALL clear on entry to IDLE.
REQ-020 Without BUTTON_REPEAT_EN, no repeat counter logic SHALL exist, and press_pulse SHALL fire only per REQ-008.

Structure
REQ-021 Package pacman_input_pkg SHALL hold:
- NUM_BUTTONS=4;
- the debounce FSM state enum typedef;
- the button index constants UP, DOWN, LEFT and RIGHT.
REQ-022 Sub-module debounce_bit SHALL hold one synchronizer, FSM and counter set; the top SHALL instantiate NUM_BUTTONS copies.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, ACTIVE_LOW=1)
REQ-023 Clean press: raw[0] driven 0 and held -> buttons[0]=1 and a single press_pulse[0] on edge 6; any_held=1.
REQ-024 Bounce: raw[1] low for 3 cycles, high for 1, then low for 2 -> buttons=0 and press_pulse=0 throughout.
REQ-025 Release glitch: from HELD, raw[2] high for 2 cycles then low -> buttons[2] stays 1 with no new pulse; raw high for 4+ cycles -> buttons[2]=0 after 6 edges.
REQ-026 Repeat (macro defined): raw[3] held 60 cycles -> pulses at HELD entry, +20, +28, +36, +44 and so on; macro undefined -> one pulse only.
REQ-027 Reset mid-press: HRESETn pulsed low during PRESS_WAIT -> all outputs 0 immediately; key still held -> pulse 6 edges after reset release.
REQ-028 Simultaneous: raw[0] and raw[3] asserted on the same edge -> press_pulse=4'b1001 in one cycle.
